segments_to_digits: RTL and testbench

Decodes a multiplexed, active-low seven-segment display bus back into hex digit values. It is the receive-side counterpart of the digit-to-segment encoder, used as a display monitor in self-checking benches and for board loopback tests. It samples segment and anode lines, requires each pattern to hold for several cycles before accepting it, and reconstructs per-digit values. Once every digit position has been refreshed, it publishes a complete frame through a valid/ready handshake.

---
 rtl/segments_to_digits_if.sv | 12 +
 rtl/segments_to_digits.sv | 129 ++++++++++++
 tb/tb_segments_to_digits.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/segments_to_digits_if.sv
// Frame handshake between the segment decoder and its consumer.
// The decoder is the master: it offers frame_digits/frame_valid and receives frame_ready.
interface segments_to_digits_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] frame_digits;
  logic                  frame_valid;
  logic                  frame_ready;

  modport master (output frame_digits, output frame_valid, input frame_ready);
  modport slave  (input frame_digits, input frame_valid, output frame_ready);
endinterface

// File: rtl/segments_to_digits.sv
// Receive-side decoder for a multiplexed active-low seven-segment bus.
// Debounces each anode/segment pattern, decodes hex digits and publishes full frames.
module segments_to_digits #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            segs_n,
  input  logic [N_DIGITS-1:0]   an_n,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic                  err,
  segments_to_digits_if.master  frm
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int KW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [6:0]            s_reg, s_prev;
  logic [N_DIGITS-1:0]   a_reg, a_prev;
  logic [CW-1:0]         cnt, cnt_next;
  logic [N_DIGITS-1:0]   seen, cap_bit;
  logic [3:0]            lows;
  logic [KW-1:0]         sel_idx;
  logic                  sel_ok, changed, capture, legal, blank, load;
  logic [3:0]            value;
  logic [6:0]            p;
  logic [4*N_DIGITS-1:0] digits_next;
  logic [N_DIGITS-1:0]   valid_next;

  // Active-high pattern {G..A} to hex value; legal flag in bit 4.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h58: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    lows    = 4'd0;
    sel_idx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!a_reg[i]) begin
        lows    = lows + 4'd1;
        sel_idx = KW'(i);
      end
    end
    sel_ok  = (lows == 4'd1);
    changed = ({a_reg, s_reg} != {a_prev, s_prev});

    if (!sel_ok)             cnt_next = '0;
    else if (changed)        cnt_next = CW'(1);
    else if (cnt == CNT_MAX) cnt_next = CNT_MAX;
    else                     cnt_next = cnt + CW'(1);

    // The changed term keeps single-cycle windows capturing on every new pattern.
    capture = sel_ok && (cnt_next == CNT_MAX) && (changed || (cnt != CNT_MAX));

    p              = ~s_reg;
    {legal, value} = decode(p);
    blank          = (p == 7'h00);

    digits_next = digits;
    valid_next  = digit_valid;
    cap_bit     = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (capture && (sel_idx == KW'(i))) begin
        cap_bit[i] = 1'b1;
        valid_next[i] = legal;
        if (legal) digits_next[4*i +: 4] = value;
      end
    end

    load = (&seen) && (!frm.frame_valid || frm.frame_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg            <= '1;
      a_reg            <= '1;
      s_prev           <= '1;
      a_prev           <= '1;
      cnt              <= '0;
      seen             <= '0;
      digits           <= '0;
      digit_valid      <= '0;
      err              <= 1'b0;
      frm.frame_digits <= '0;
      frm.frame_valid  <= 1'b0;
    end else begin
      s_reg       <= segs_n;
      a_reg       <= an_n;
      s_prev      <= s_reg;
      a_prev      <= a_reg;
      cnt         <= cnt_next;
      digits      <= digits_next;
      digit_valid <= valid_next;
      err         <= capture && !legal && !blank;
      seen        <= (load ? '0 : seen) | cap_bit;
      // Frame takes the pre-capture digits; a capture on this edge lands in the next frame.
      if (load) begin
        frm.frame_digits <= digits;
        frm.frame_valid  <= 1'b1;
      end else if (frm.frame_valid && frm.frame_ready) begin
        frm.frame_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_segments_to_digits.sv
// Self-checking bench for segments_to_digits: debounce timing, decode, errors and frames.
module tb_segments_to_digits;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  segs_n;
  logic [3:0]  an_n;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        err;

  int checks = 0;
  int errors = 0;
  int err_total = 0;
  int err_wide = 0;
  logic err_q = 1'b0;
  logic [15:0] sb_q[$];

  segments_to_digits_if #(.N_DIGITS(4)) frm ();

  segments_to_digits #(.N_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .segs_n      (segs_n),
    .an_n        (an_n),
    .digits      (digits),
    .digit_valid (digit_valid),
    .err         (err),
    .frm         (frm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] t[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};
    return t[v];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] sg, input int n);
    an_n   = an;
    segs_n = sg;
    tick(n);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    an_n   = 4'hF;
    segs_n = 7'h7F;
    tick(2);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (err) err_total++;
    if (err && err_q) err_wide++;
    err_q = err;
    if (frm.frame_valid && frm.frame_ready) begin
      if (sb_q.size() == 0) chk("sb_unexpected_frame", 32'(frm.frame_digits), 32'hFFFF_FFFF);
      else chk("sb_frame", 32'(frm.frame_digits), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    int e0;
    frm.frame_ready = 1'b0;

    // Reset with random pins
    rst    = 1'b1;
    segs_n = 7'($urandom);
    an_n   = 4'($urandom);
    tick(2);
    chk("rst_digits", 32'(digits), 0);
    chk("rst_valid", 32'(digit_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_fv", 32'(frm.frame_valid), 0);
    chk("rst_fd", 32'(frm.frame_digits), 0);
    rst  = 1'b0;
    an_n = 4'hF;
    tick(1);
    chk("rel_digits", 32'(digits), 0);
    chk("rel_fv", 32'(frm.frame_valid), 0);

    // Single digit: capture visible after edge 5, not after edge 4
    do_reset();
    e0 = err_total;
    drive(4'b1110, ~7'h5B, 4);
    chk("single_early_valid", 32'(digit_valid), 0);
    tick(1);
    chk("single_digit", 32'(digits[3:0]), 2);
    chk("single_valid", 32'(digit_valid), 4'b0001);
    tick(3);
    chk("single_err", 32'(err_total - e0), 0);
    chk("single_fv", 32'(frm.frame_valid), 0);

    // Glitch on the 3rd cycle restarts the window
    do_reset();
    drive(4'b1110, ~7'h5B, 2);
    drive(4'b1110, ~7'h4F, 4);
    chk("glitch_no_cap", 32'(digit_valid), 0);
    tick(1);
    chk("glitch_digit", 32'(digits[3:0]), 3);
    chk("glitch_valid", 32'(digit_valid), 4'b0001);

    // Illegal and blank patterns on position 1
    do_reset();
    drive(4'b1101, ~seg7(4'd5), 6);
    chk("pre_ill_digit", 32'(digits[7:4]), 5);
    chk("pre_ill_valid", 32'(digit_valid[1]), 1);
    e0 = err_total;
    drive(4'b1101, ~7'h01, 6);
    chk("ill_err_count", 32'(err_total - e0), 1);
    chk("ill_err_wide", 32'(err_wide), 0);
    chk("ill_valid", 32'(digit_valid[1]), 0);
    chk("ill_digit", 32'(digits[7:4]), 5);
    drive(4'b1101, ~seg7(4'd7), 6);
    chk("relegal_valid", 32'(digit_valid[1]), 1);
    e0 = err_total;
    drive(4'b1101, 7'h7F, 6);
    chk("blank_err", 32'(err_total - e0), 0);
    chk("blank_valid", 32'(digit_valid[1]), 0);
    chk("blank_digit", 32'(digits[7:4]), 7);

    // Full scan with backpressure, then drain
    do_reset();
    sb_q.push_back(16'h4321);
    for (int i = 0; i < 4; i++) drive(~(4'b0001 << i), ~seg7(4'(i + 1)), 6);
    chk("scan1_fv", 32'(frm.frame_valid), 1);
    chk("scan1_fd", 32'(frm.frame_digits), 16'h4321);
    sb_q.push_back(16'h8765);
    for (int i = 0; i < 4; i++) drive(~(4'b0001 << i), ~seg7(4'(i + 5)), 6);
    chk("bp_fd_frozen", 32'(frm.frame_digits), 16'h4321);
    chk("bp_digits", 32'(digits), 16'h8765);
    chk("bp_fv", 32'(frm.frame_valid), 1);
    frm.frame_ready = 1'b1;
    tick(1);
    chk("next_fd", 32'(frm.frame_digits), 16'h8765);
    chk("next_fv", 32'(frm.frame_valid), 1);
    tick(2);
    frm.frame_ready = 1'b0;
    chk("drain_fv", 32'(frm.frame_valid), 0);
    chk("sb_left", 32'(sb_q.size()), 0);

    // Two anodes low: no selection
    do_reset();
    e0 = err_total;
    drive(4'b1100, ~seg7(4'd6), 10);
    chk("multi_valid", 32'(digit_valid), 0);
    chk("multi_digits", 32'(digits), 0);
    chk("multi_err", 32'(err_total - e0), 0);

    // Reset at count 3 discards the run
    do_reset();
    drive(4'b1110, ~seg7(4'd9), 4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_valid", 32'(digit_valid), 0);
    tick(4);
    chk("midrst_early", 32'(digit_valid), 0);
    tick(1);
    chk("midrst_digit", 32'(digits[3:0]), 9);
    chk("midrst_cap", 32'(digit_valid), 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
